// File: rtl/spi_memory_arbiter.sv
// Two-port arbiter sharing one synchronous single-port memory between the SPI host (A) and the core (B).
// Build option SPI_MEM_ARB_ROUND_ROBIN_EN: round-robin tie break; default build uses fixed A priority.
module spi_memory_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr
);

    // state    | meaning
    // IDLE     | arbitrate; the previous transfer's ack may be high here
    // ACCESS   | exactly one memory strobe is high
    // COMPLETE | memory read data valid; capture it and register the ack
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata;
    logic [DATA_WIDTH-1:0] r_a_rdata,   w_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata,   w_b_rdata;
    logic                  r_mem_rd,    w_mem_rd;
    logic                  r_mem_wr,    w_mem_wr;
    logic                  r_a_ack,     w_a_ack;
    logic                  r_b_ack,     w_b_ack;
    logic                  r_owner_b,   w_owner_b;
    logic                  r_wr,        w_wr;

    logic w_ack_any;
    logic w_a_elig;
    logic w_b_elig;
    logic w_grant;
    logic w_grant_b;

    // The ack cycle is a turnaround: a requester still holding req there is
    // finishing, not asking again, so no new grant is issued in that cycle.
    assign w_ack_any = r_a_ack | r_b_ack;
    assign w_a_elig  = a_req & ~w_ack_any;
    assign w_b_elig  = b_req & ~w_ack_any;
    assign w_grant   = (r_state == IDLE) & (w_a_elig | w_b_elig);

`ifdef SPI_MEM_ARB_ROUND_ROBIN_EN
    logic r_last_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_a <= 1'b0;
        end else if (w_grant) begin
            r_last_a <= ~w_grant_b;
        end
    end

    assign w_grant_b = w_b_elig & (~w_a_elig | r_last_a);
`else
    assign w_grant_b = w_b_elig & ~w_a_elig;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_grant) w_state_nxt = ACCESS;
            ACCESS:   w_state_nxt = COMPLETE;
            COMPLETE: w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_a_rdata   = r_a_rdata;
        w_b_rdata   = r_b_rdata;
        w_owner_b   = r_owner_b;
        w_wr        = r_wr;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_a_ack     = 1'b0;
        w_b_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_owner_b   = w_grant_b;
                    w_wr        = w_grant_b ? b_wr    : a_wr;
                    w_mem_addr  = w_grant_b ? b_addr  : a_addr;
                    w_mem_wdata = w_grant_b ? b_wdata : a_wdata;
                    w_mem_rd    = ~w_wr;
                    w_mem_wr    = w_wr;
                end
            end
            COMPLETE: begin
                if (!r_wr) begin
                    if (r_owner_b) w_b_rdata = mem_rdata;
                    else           w_a_rdata = mem_rdata;
                end
                w_a_ack = ~r_owner_b;
                w_b_ack = r_owner_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_owner_b   <= 1'b0;
            r_wr        <= 1'b0;
        end else begin
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_a_rdata   <= w_a_rdata;
            r_b_rdata   <= w_b_rdata;
            r_mem_rd    <= w_mem_rd;
            r_mem_wr    <= w_mem_wr;
            r_a_ack     <= w_a_ack;
            r_b_ack     <= w_b_ack;
            r_owner_b   <= w_owner_b;
            r_wr        <= w_wr;
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_rd    = r_mem_rd;
    assign mem_wr    = r_mem_wr;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign a_ack     = r_a_ack;
    assign b_ack     = r_b_ack;

endmodule

// File: tb/tb_spi_memory_arbiter.sv
// Directed bench for spi_memory_arbiter; memory model returns the low address byte one cycle after mem_rd.
module tb_spi_memory_arbiter;

`ifdef SPI_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        a_req, a_wr, b_req, b_wr;
    logic [15:0] a_addr, b_addr, mem_addr;
    logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
    logic        a_ack, b_ack, mem_rd, mem_wr;

    spi_memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_rdata <= mem_rd ? mem_addr[7:0] : 8'h5a;

    typedef struct {
        logic        a_req;
        logic        a_wr;
        logic [15:0] a_addr;
        logic [7:0]  a_wdata;
        logic        b_req;
        logic        b_wr;
        logic [15:0] b_addr;
        logic [7:0]  b_wdata;
        logic        exp_b;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_a_rdata = 8'h00;
    logic [7:0] exp_b_rdata = 8'h00;
    vec_t       vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        a_req = v.a_req; a_wr = v.a_wr; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_req = v.b_req; b_wr = v.b_wr; b_addr = v.b_addr; b_wdata = v.b_wdata;
        @(negedge clk);
        chk("strobe_rd", 32'(mem_rd), 32'(!v.exp_wr));
        chk("strobe_wr", 32'(mem_wr), 32'(v.exp_wr));
        chk("mem_addr", 32'(mem_addr), 32'(v.exp_addr));
        if (v.exp_wr) chk("mem_wdata", 32'(mem_wdata), 32'(v.exp_wdata));
        chk("ack_in_access", 32'({a_ack, b_ack}), 32'd0);
        @(negedge clk);
        chk("strobe_off", 32'({mem_rd, mem_wr}), 32'd0);
        chk("ack_in_complete", 32'({a_ack, b_ack}), 32'd0);
        @(negedge clk);
        chk("ack_a", 32'(a_ack), 32'(!v.exp_b));
        chk("ack_b", 32'(b_ack), 32'(v.exp_b));
        if (!v.exp_wr) begin
            if (v.exp_b) exp_b_rdata = v.exp_rdata;
            else         exp_a_rdata = v.exp_rdata;
        end
        chk("rdata_a", 32'(a_rdata), 32'(exp_a_rdata));
        chk("rdata_b", 32'(b_rdata), 32'(exp_b_rdata));
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("ack_pulse", 32'({a_ack, b_ack}), 32'd0);
    endtask

    initial begin
        int          nacks, nstrobes, nb, both, sc, k;
        logic        ep;
        logic [15:0] addrs[3];
        logic [7:0]  datas[3];

        vecs[0] = '{1'b1, 1'b1, 16'h5ead, 8'h01, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h5ead, 8'h01, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h6eef, 8'h00, 1'b1, 1'b0, 16'h6eef, 8'h00, 8'hef};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h1234, 8'h00, 8'h34};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'habcd, 8'h77, 1'b1, 1'b1, 16'habcd, 8'h77, 8'h00};
        vecs[4] = '{1'b1, 1'b0, 16'h00ff, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h00ff, 8'h00, 8'hff};
        vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 1'b0, 16'h8000, 8'h00, 8'h00};

        // Reset with both requests held, then four tied transfers
        reset = 1'b1;
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h1111; a_wdata = 8'h00;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 16'h2222; b_wdata = 8'h00;
        repeat (3) begin
            @(negedge clk);
            chk("reset_ctl", 32'({mem_rd, mem_wr, a_ack, b_ack}), 32'd0);
            chk("reset_mem", 32'({mem_addr, mem_wdata}), 32'd0);
            chk("reset_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        end
        reset = 1'b0;
        nacks = 0; nstrobes = 0; nb = 0; both = 0; sc = 0;
        for (int c = 0; c < 60 && nacks < 4; c++) begin
            @(negedge clk);
            if (a_ack && b_ack) both++;
            if (mem_rd && mem_wr) both++;
            if (mem_rd || mem_wr) begin
                ep = RR ? nstrobes[0] : 1'b0;
                if (nstrobes == 0) chk("first_grant_latency", 32'(c), 32'd0);
                chk("tie_grant_addr", 32'(mem_addr), ep ? 32'h2222 : 32'h1111);
                sc = c;
                nstrobes++;
            end
            if (a_ack || b_ack) begin
                ep = RR ? nacks[0] : 1'b0;
                if (b_ack) nb++;
                chk("tie_ack_port", 32'({a_ack, b_ack}), ep ? 32'd1 : 32'd2);
                chk("tie_ack_latency", 32'(c - sc), 32'd2);
                if (ep) exp_b_rdata = 8'h22;
                else    exp_a_rdata = 8'h11;
                chk("tie_rdata_a", 32'(a_rdata), 32'(exp_a_rdata));
                chk("tie_rdata_b", 32'(b_rdata), 32'(exp_b_rdata));
                nacks++;
                if (nacks == 4) begin
                    a_req = 1'b0; b_req = 1'b0;
                end
            end
        end
        chk("tie_transfers", 32'(nacks), 32'd4);
        chk("tie_b_acks", 32'(nb), RR ? 32'd2 : 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("tie_idle", 32'({a_ack, b_ack, mem_rd, mem_wr}), 32'd0);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Back-to-back A reads with req held across the ack
        addrs[0] = 16'h7ffe; addrs[1] = 16'h7fff; addrs[2] = 16'h8000;
        datas[0] = 8'hfe;    datas[1] = 8'hff;    datas[2] = 8'h00;
        k = 0; nb = 0; sc = 0;
        a_req = 1'b1; a_wr = 1'b0; a_addr = addrs[0];
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (b_ack) nb++;
            if (mem_rd || mem_wr) begin
                chk("b2b_strobe_rd", 32'({mem_rd, mem_wr}), 32'd2);
                chk("b2b_addr", 32'(mem_addr), 32'(addrs[k]));
                sc = c;
            end
            if (a_ack) begin
                chk("b2b_rdata", 32'(a_rdata), 32'(datas[k]));
                chk("b2b_latency", 32'(c - sc), 32'd2);
                exp_a_rdata = datas[k];
                k++;
                if (k < 3) a_addr = addrs[k];
                else       a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        chk("b2b_count", 32'(k), 32'd3);
        chk("b2b_no_b_ack", 32'(nb), 32'd0);
        chk("b2b_b_rdata", 32'(b_rdata), 32'(exp_b_rdata));
        @(negedge clk);

        // Reset during the ACCESS cycle of a read
        a_req = 1'b1; a_wr = 1'b0; a_addr = 16'h4444;
        @(negedge clk);
        chk("abort_strobe", 32'(mem_rd), 32'd1);
        reset = 1'b1; a_req = 1'b0;
        @(negedge clk);
        chk("abort_strobe_drop", 32'({mem_rd, mem_wr}), 32'd0);
        chk("abort_ack_drop", 32'({a_ack, b_ack}), 32'd0);
        reset = 1'b0;
        exp_a_rdata = 8'h00; exp_b_rdata = 8'h00;
        nacks = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack || b_ack) nacks++;
        end
        chk("abort_no_ack", 32'(nacks), 32'd0);
        chk("abort_rdata", 32'({a_rdata, b_rdata}), 32'd0);
        apply_vec('{1'b1, 1'b0, 16'h0099, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0099, 8'h00, 8'h99});

        chk("never_both", 32'(both), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
